// File: rtl/branch_flag_unit.sv
// Branch resolution at the consumer end of the flag path: holds NZCV, evaluates
// B / B.cond / CBZ / CBNZ and returns a registered taken/valid pair to fetch.
module branch_flag_unit #(
  parameter logic BYPASS = 1'b1,
  parameter int   CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             flag_we,
  input  logic [3:0]       alu_nzcv,
  input  logic             op_zero,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [3:0]       br_cond,
  output logic [3:0]       flags_q,
  output logic             taken,
  output logic             taken_valid,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // A64 condition evaluation over {N,Z,C,V}; NV (1111) behaves as always.
  function automatic logic cond_eval(input logic [3:0] nzcv, input logic [3:0] cc);
    logic n, z, c, v, r;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cc)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      4'b1111: r = 1'b1;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  logic             accept_s;
  logic             flag_wr_s;
  logic [3:0]       flag_src_s;
  logic             decision_s;
  logic [3:0]       flags_d;
  logic             taken_q, taken_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign accept_s  = br_valid & ~stall & ~flush;
  assign flag_wr_s = flag_we & ~stall & ~flush;

  assign taken       = taken_q;
  assign taken_valid = valid_q;
  assign taken_count = count_q;

  // Decision for the current request; B.cond may see this cycle's ALU flags.
  always_comb begin
    flag_src_s = flags_q;
    decision_s = 1'b0;
    if (BYPASS && flag_we) begin
      flag_src_s = alu_nzcv;
    end else begin
      flag_src_s = flags_q;
    end
    case (br_type)
      2'b00:   decision_s = 1'b1;
      2'b01:   decision_s = cond_eval(flag_src_s, br_cond);
      2'b10:   decision_s = op_zero;
      2'b11:   decision_s = ~op_zero;
      default: decision_s = 1'b0;
    endcase
  end

  // Next-state: flush clears the result, stall holds it, otherwise one result per request.
  always_comb begin
    flags_d = flags_q;
    taken_d = 1'b0;
    valid_d = 1'b0;
    count_d = count_q;
    if (flag_wr_s) begin
      flags_d = alu_nzcv;
    end else begin
      flags_d = flags_q;
    end
    if (flush) begin
      taken_d = 1'b0;
      valid_d = 1'b0;
    end else if (stall) begin
      taken_d = taken_q;
      valid_d = valid_q;
    end else if (br_valid) begin
      taken_d = decision_s;
      valid_d = 1'b1;
    end else begin
      taken_d = 1'b0;
      valid_d = 1'b0;
    end
    if (accept_s && decision_s && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
      taken_q <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      flags_q <= flags_d;
      taken_q <= taken_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Self-checking bench for branch_flag_unit: three instances (bypass, no bypass,
// 2-bit counter) share one stimulus stream and are checked against a reference model.
module tb_branch_flag_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       flag_we = 1'b0;
  logic [3:0] alu_nzcv = 4'b0000;
  logic       op_zero = 1'b0;
  logic       br_valid = 1'b0;
  logic [1:0] br_type = 2'b00;
  logic [3:0] br_cond = 4'b0000;

  logic [3:0]  flags_b, flags_n, flags_s;
  logic        taken_b, taken_n, taken_s;
  logic        valid_b, valid_n, valid_s;
  logic [15:0] cnt_b, cnt_n;
  logic [1:0]  cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [3:0] m_flags;
  bit         m_taken_b, m_taken_n, m_valid;
  int         m_cnt_b, m_cnt_n, m_cnt_s;

  always #5 clk = ~clk;

  branch_flag_unit #(.BYPASS(1'b1), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flag_we(flag_we),
    .alu_nzcv(alu_nzcv), .op_zero(op_zero), .br_valid(br_valid), .br_type(br_type),
    .br_cond(br_cond), .flags_q(flags_b), .taken(taken_b), .taken_valid(valid_b),
    .taken_count(cnt_b));

  branch_flag_unit #(.BYPASS(1'b0), .CNT_W(16)) dut_n (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flag_we(flag_we),
    .alu_nzcv(alu_nzcv), .op_zero(op_zero), .br_valid(br_valid), .br_type(br_type),
    .br_cond(br_cond), .flags_q(flags_n), .taken(taken_n), .taken_valid(valid_n),
    .taken_count(cnt_n));

  branch_flag_unit #(.BYPASS(1'b1), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flag_we(flag_we),
    .alu_nzcv(alu_nzcv), .op_zero(op_zero), .br_valid(br_valid), .br_type(br_type),
    .br_cond(br_cond), .flags_q(flags_s), .taken(taken_s), .taken_valid(valid_s),
    .taken_count(cnt_s));

  typedef struct {
    logic [3:0]  nzcv;
    logic [15:0] taken_mask;  // bit i = expected taken for br_cond i
  } sweep_vec_t;

  sweep_vec_t sweep_tbl[7];

  // Architectural ConditionHolds: base test from cc[3:1], inverted by cc[0] except for 1111.
  function automatic bit cond_holds(input logic [3:0] f, input logic [3:0] cc);
    bit n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = (n == v) && !z;
      default: r = 1'b1;
    endcase
    if (cc[0] && cc != 4'hF) r = !r;
    return r;
  endfunction

  function automatic bit m_decide(input logic [1:0] t, input logic [3:0] f,
                                  input logic [3:0] cc, input bit oz);
    case (t)
      2'b00:   return 1'b1;
      2'b01:   return cond_holds(f, cc);
      2'b10:   return oz;
      default: return !oz;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("flags_b", 32'(flags_b), 32'(m_flags));
    check("flags_n", 32'(flags_n), 32'(m_flags));
    check("flags_s", 32'(flags_s), 32'(m_flags));
    check("taken_b", 32'(taken_b), 32'(m_taken_b));
    check("taken_n", 32'(taken_n), 32'(m_taken_n));
    check("taken_s", 32'(taken_s), 32'(m_taken_b));
    check("valid_b", 32'(valid_b), 32'(m_valid));
    check("valid_n", 32'(valid_n), 32'(m_valid));
    check("valid_s", 32'(valid_s), 32'(m_valid));
    check("count_b", 32'(cnt_b), 32'(m_cnt_b));
    check("count_n", 32'(cnt_n), 32'(m_cnt_n));
    check("count_s", 32'(cnt_s), 32'(m_cnt_s));
  endtask

  task automatic drive(input bit st, input bit fl, input bit we, input logic [3:0] alu,
                       input bit oz, input bit bv, input logic [1:0] bt, input logic [3:0] bc);
    stall = st; flush = fl; flag_we = we; alu_nzcv = alu;
    op_zero = oz; br_valid = bv; br_type = bt; br_cond = bc;
  endtask

  task automatic model_clear();
    m_flags = 4'b0000; m_taken_b = 1'b0; m_taken_n = 1'b0; m_valid = 1'b0;
    m_cnt_b = 0; m_cnt_n = 0; m_cnt_s = 0;
  endtask

  // One clock: predict from the inputs present at the edge, then compare after it.
  task automatic cycle();
    bit acc, db, dn;
    acc = br_valid && !stall && !flush;
    db  = m_decide(br_type, flag_we ? alu_nzcv : m_flags, br_cond, op_zero);
    dn  = m_decide(br_type, m_flags, br_cond, op_zero);
    @(posedge clk);
    if (acc) begin
      m_valid = 1'b1; m_taken_b = db; m_taken_n = dn;
      if (db) begin
        m_cnt_b = (m_cnt_b < 65535) ? m_cnt_b + 1 : m_cnt_b;
        m_cnt_s = (m_cnt_s < 3) ? m_cnt_s + 1 : m_cnt_s;
      end
      if (dn) m_cnt_n = (m_cnt_n < 65535) ? m_cnt_n + 1 : m_cnt_n;
    end else if (flush || !stall) begin
      m_valid = 1'b0; m_taken_b = 1'b0; m_taken_n = 1'b0;
    end
    if (flag_we && !stall && !flush) m_flags = alu_nzcv;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 4'h0, 0, 0, 2'b00, 4'h0);
    reset = 1'b0;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    sweep_tbl[0] = '{4'b0000, 16'hD6AA};
    sweep_tbl[1] = '{4'b0100, 16'hE6A9};
    sweep_tbl[2] = '{4'b1000, 16'hEA9A};
    sweep_tbl[3] = '{4'b0001, 16'hEA6A};
    sweep_tbl[4] = '{4'b1001, 16'hD65A};
    sweep_tbl[5] = '{4'b0010, 16'hD5A6};
    sweep_tbl[6] = '{4'b0110, 16'hE6A5};

    do_reset();
    check("reset_flags", 32'(flags_b), 32'h0);

    // flag write then B.cond EQ / NE
    drive(0, 0, 1, 4'b0100, 0, 0, 2'b00, 4'h0); cycle();
    check("write_flags", 32'(flags_b), 32'h4);
    drive(0, 0, 0, 4'h0, 0, 1, 2'b01, 4'b0000); cycle();
    check("eq_taken", 32'(taken_b), 32'h1);
    drive(0, 0, 0, 4'h0, 0, 1, 2'b01, 4'b0001); cycle();
    check("ne_taken", 32'(taken_b), 32'h0);

    // bypass versus registered flags
    drive(0, 0, 1, 4'b0000, 0, 0, 2'b00, 4'h0); cycle();
    drive(0, 0, 1, 4'b0100, 0, 1, 2'b01, 4'b0000); cycle();
    check("bypass_on", 32'(taken_b), 32'h1);
    check("bypass_off", 32'(taken_n), 32'h0);
    check("bypass_off_flags", 32'(flags_n), 32'h4);

    // full condition sweep, back-to-back B.cond requests
    for (int e = 0; e < 7; e++) begin
      drive(0, 0, 1, sweep_tbl[e].nzcv, 0, 0, 2'b00, 4'h0); cycle();
      for (int c = 0; c < 16; c++) begin
        drive(0, 0, 0, 4'h0, 0, 1, 2'b01, 4'(c)); cycle();
        check($sformatf("sweep_b nzcv=%b cc=%0d", sweep_tbl[e].nzcv, c),
              32'(taken_b), 32'(sweep_tbl[e].taken_mask[c]));
        check($sformatf("sweep_n nzcv=%b cc=%0d", sweep_tbl[e].nzcv, c),
              32'(taken_n), 32'(sweep_tbl[e].taken_mask[c]));
      end
    end

    // CBZ / CBNZ; flags 0110 from the last sweep entry
    drive(0, 0, 0, 4'h0, 1, 1, 2'b10, 4'h0); cycle(); check("cbz_oz1", 32'(taken_b), 32'h1);
    drive(0, 0, 0, 4'h0, 1, 1, 2'b11, 4'h0); cycle(); check("cbnz_oz1", 32'(taken_b), 32'h0);
    drive(0, 0, 0, 4'h0, 0, 1, 2'b10, 4'h0); cycle(); check("cbz_oz0", 32'(taken_b), 32'h0);
    drive(0, 0, 0, 4'h0, 0, 1, 2'b11, 4'h0); cycle(); check("cbnz_oz0", 32'(taken_b), 32'h1);
    check("cb_flags_kept", 32'(flags_b), 32'h6);
    drive(0, 0, 1, 4'b1010, 0, 1, 2'b10, 4'h0); cycle();
    check("cb_flag_write", 32'(flags_b), 32'hA);
    check("cb_flag_write_taken", 32'(taken_b), 32'h0);

    // stall holds a taken result and blocks the flag write
    drive(0, 0, 1, 4'b0000, 0, 1, 2'b00, 4'h0); cycle();
    drive(1, 0, 1, 4'b1111, 0, 1, 2'b01, 4'b0000); cycle();
    check("stall_taken", 32'(taken_b), 32'h1);
    check("stall_valid", 32'(valid_b), 32'h1);
    check("stall_flags", 32'(flags_b), 32'h0);
    drive(1, 0, 0, 4'h0, 0, 0, 2'b00, 4'h0); cycle();
    check("stall2_valid", 32'(valid_b), 32'h1);
    // flush overrides stall, drops request and flag write
    drive(1, 1, 1, 4'b1111, 0, 1, 2'b00, 4'h0); cycle();
    check("flush_valid", 32'(valid_b), 32'h0);
    check("flush_taken", 32'(taken_b), 32'h0);
    check("flush_flags", 32'(flags_b), 32'h0);

    // saturation of the 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 4'h0, 0, 1, 2'b00, 4'h0); cycle();
    end
    check("sat_count2", 32'(cnt_s), 32'h3);
    check("count16_five", 32'(cnt_b), 32'h5);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, 1'($urandom),
            4'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
            2'($urandom), 4'($urandom));
      cycle();
    end

    // async reset mid-cycle with a pending result and nonzero flags
    drive(0, 0, 1, 4'b1101, 0, 1, 2'b00, 4'h0); cycle();
    check("pre_reset_valid", 32'(valid_b), 32'h1);
    drive(0, 0, 0, 4'h0, 0, 0, 2'b00, 4'h0);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", 32'(valid_b), 32'h0);
    check("async_taken", 32'(taken_b), 32'h0);
    check("async_flags", 32'(flags_b), 32'h0);
    check("async_count", 32'(cnt_b), 32'h0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 4'h0, 0, 1, 2'b00, 4'h0); cycle();
    check("post_reset_taken", 32'(taken_b), 32'h1);
    drive(0, 0, 0, 4'h0, 0, 0, 2'b00, 4'h0); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Consumer end of the zero/flag path.
- Holds the architectural NZCV flag register written by flag-setting ALU ops, including the Z bit from the 64-bit zero detector.
- Evaluates B.cond, CBZ and CBNZ against those flags or against the operand zero flag, and returns a registered taken/valid result to the fetch/PC logic.
- Sits between EX (flag producer) and the PC-select mux; also keeps a saturating taken-branch counter for debug.

Parameters:
- BYPASS, 1, 1 = a B.cond in the same cycle as a flag write uses the new ALU flags; 0 = uses the registered flags.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- stall  input  1  pipeline hold: no state changes, outputs held
- flush  input  1  squash: drops this cycle's request and flag write
- flag_we  input  1  ALU op sets flags this cycle
- alu_nzcv  input  4  {N,Z,C,V} from ALU; Z sourced from the 64-bit zero detector
- op_zero  input  1  zero-detect of the CBZ/CBNZ register operand
- br_valid  input  1  branch request present
- br_type  input  2  00 B (unconditional), 01 B.cond, 10 CBZ, 11 CBNZ
- br_cond  input  4  A64 condition code; used only for B.cond
- flags_q  output  4  registered NZCV
- taken  output  1  registered branch decision
- taken_valid  output  1  taken corresponds to an accepted request
- taken_count  output  CNT_W  saturating count of taken branches

Behaviour:
- Reset (reset=0, async): flags_q=0000, taken=0, taken_valid=0, taken_count=0. Deassertion is sampled at the next clk edge; no request is accepted in the cycle reset is low.

Flag register:
- On a clk edge, flags_q<=alu_nzcv iff flag_we & !stall & !flush. Otherwise it holds.

Request acceptance:
- Accepted iff br_valid & !stall & !flush.
- Latency is 1 cycle: the edge that accepts the request sets taken_valid=1 and taken=decision.
- On a non-accepting edge:
  - stall=1: taken and taken_valid hold.
  - otherwise: taken_valid<=0, taken<=0.
- flush has priority over stall. flush=1 forces taken_valid<=0 and taken<=0 and blocks the flag write.

Flag source for B.cond:
- F = alu_nzcv if BYPASS & flag_we, else flags_q.
- With BYPASS=0, a same-cycle flag write is not visible to the B.cond; it uses the old flags.

Decision by br_type:
- 00: 1.
- 10: op_zero.
- 11: !op_zero.
- 01: cond(F, br_cond), where:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 NV 1 (A64 treats NV as always)

Other rules:
- CBZ/CBNZ neither read nor modify flags. A simultaneous flag_we is still written to flags_q.
- taken_count increments by 1 on each accepting edge with decision=1. It saturates at 2^CNT_W-1 with no wrap and is cleared only by reset.
- Back-to-back requests on consecutive cycles are each evaluated independently, one result per cycle.
- Reset asserted mid-operation clears all state immediately, without waiting for clk. A pending result is lost.

Test Plan:
- Reset then idle: after reset, reset=0 mid-cycle with taken_valid=1 → taken_valid, taken, flags_q and taken_count go to 0 before the next edge.
- Flag write: flag_we=1, alu_nzcv=0100, then B.cond EQ next cycle → flags_q=0100, taken=1 one cycle after the request. NE with the same flags → taken=0.
- Bypass: flags_q=0000, same cycle flag_we=1, alu_nzcv=0100, B.cond EQ → BYPASS=1: taken=1; BYPASS=0: taken=0, and flags_q=0100 afterwards.
- Full condition sweep: for each NZCV in {0000, 0100, 1000, 0001, 1001, 0010, 0110}, all 16 br_cond values → taken matches the table. GE/LT flip for N=1,V=0 versus N=1,V=1.
- CBZ/CBNZ: op_zero=1 → CBZ taken=1, CBNZ taken=0; op_zero=0 → reversed. flags_q is unchanged unless flag_we=1.
- Stall/flush/saturation:
  - stall=1 with br_valid → taken/taken_valid held, flags unchanged.
  - flush=1 with br_valid and flag_we → next taken_valid=0, flags_q unchanged.
  - CNT_W=2 with 5 taken branches → taken_count=3.
